// File: rtl/vga_pkg.sv
// Shared definitions for the VGA pattern sequencer: default 640x480@60 timing,
// frame-boundary constants, the debounce FSM state type and a window decoder.
package vga_pkg;

    // Default horizontal timing (pixels)
    localparam int H_ACTIVE_D  = 640;
    localparam int H_FP_D      = 16;
    localparam int H_SYNC_D    = 96;
    localparam int H_BP_D      = 48;
    localparam int H_TOTAL_D   = H_ACTIVE_D + H_FP_D + H_SYNC_D + H_BP_D;

    // Default vertical timing (lines)
    localparam int V_ACTIVE_D  = 480;
    localparam int V_FP_D      = 10;
    localparam int V_SYNC_D    = 2;
    localparam int V_BP_D      = 33;
    localparam int V_TOTAL_D   = V_ACTIVE_D + V_FP_D + V_SYNC_D + V_BP_D;

    // Default frame boundary: last pixel of the last line
    localparam int H_LAST_D    = H_TOTAL_D - 1;
    localparam int V_LAST_D    = V_TOTAL_D - 1;

    // Default key debounce and auto-cycle settings
    localparam int DEB_CYCLES_D  = 250000;
    localparam int AUTO_FRAMES_D = 60;

    localparam int CNT_W = 10;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_PRESS_WAIT = 2'd1,
        ST_HELD       = 2'd2,
        ST_REL_WAIT   = 2'd3
    } deb_state_t;

    // True when cnt lies in [first, first+len)
    function automatic logic in_window(input logic [CNT_W-1:0] cnt, input int first, input int len);
        return (int'(cnt) >= first) && (int'(cnt) < first + len);
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Push-button conditioner: 2-flop synchronizer followed by a four-state
// debounce FSM that emits a single-cycle pulse when a press is accepted.
module key_debounce
    import vga_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_D
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_key,
    output logic o_press
);

    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic [1:0]    r_sync;
    deb_state_t    r_state;
    logic [CW-1:0] r_cnt;
    logic          r_press;

    deb_state_t    w_state_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_press_nxt;
    logic          w_key_s;

    assign w_key_s = r_sync[1];
    assign o_press = r_press;

    // Bring the asynchronous key into the clock domain; idle level is high
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], i_key};
        end
    end

    // FSM state, stability counter and registered press pulse
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_press <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_press <= w_press_nxt;
        end
    end

    // Next-state: a level must hold for DEB_CYCLES samples to be accepted
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_press_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = '0;
                if (!w_key_s) begin
                    w_state_nxt = ST_PRESS_WAIT;
                end
            end
            ST_PRESS_WAIT: begin
                if (w_key_s) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = ST_HELD;
                    w_cnt_nxt   = '0;
                    w_press_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            ST_HELD: begin
                w_cnt_nxt = '0;
                if (w_key_s) begin
                    w_state_nxt = ST_REL_WAIT;
                end
            end
            ST_REL_WAIT: begin
                if (!w_key_s) begin
                    w_state_nxt = ST_HELD;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

endmodule

// File: rtl/vga_pattern_sequencer.sv
// VGA timing generator with a pattern-select bit that toggles only on frame
// boundaries, driven by a debounced push-button and/or an auto-cycle timer.
module vga_pattern_sequencer
    import vga_pkg::*;
#(
    parameter int H_ACTIVE    = H_ACTIVE_D,
    parameter int H_FP        = H_FP_D,
    parameter int H_SYNC      = H_SYNC_D,
    parameter int H_BP        = H_BP_D,
    parameter int V_ACTIVE    = V_ACTIVE_D,
    parameter int V_FP        = V_FP_D,
    parameter int V_SYNC      = V_SYNC_D,
    parameter int V_BP        = V_BP_D,
    parameter int DEB_CYCLES  = DEB_CYCLES_D,
    parameter int AUTO_FRAMES = AUTO_FRAMES_D
) (
    input  logic             iVGA_CLK,
    input  logic             iRST,
    input  logic             iKey,
    input  logic             iAuto_EN,
    output logic [CNT_W-1:0] oVGA_X,
    output logic [CNT_W-1:0] oVGA_Y,
    output logic             oHS,
    output logic             oVS,
    output logic             oBLANK_n,
    output logic             oColor_SW,
    output logic             oFrame_Start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
    localparam logic [7:0]       AUTO_LAST = 8'(AUTO_FRAMES - 1);

    logic [CNT_W-1:0] r_h_cnt;
    logic [CNT_W-1:0] r_v_cnt;
    logic             r_hs;
    logic             r_vs;
    logic             r_blank_n;
    logic             r_color;
    logic             r_pending;
    logic [7:0]       r_frame_cnt;

    logic w_press;
    logic w_h_last;
    logic w_v_last;
    logic w_frame_end;
    logic w_auto_req;
    logic w_toggle;

    key_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_key_debounce (
        .i_clk   (iVGA_CLK),
        .i_rst   (iRST),
        .i_key   (iKey),
        .o_press (w_press)
    );

    assign w_h_last    = (r_h_cnt == H_LAST);
    assign w_v_last    = (r_v_cnt == V_LAST);
    assign w_frame_end = w_h_last && w_v_last;
    assign w_auto_req  = iAuto_EN && (r_frame_cnt == AUTO_LAST);
    assign w_toggle    = r_pending || w_auto_req;

    assign oVGA_X       = r_h_cnt;
    assign oVGA_Y       = r_v_cnt;
    assign oHS          = r_hs;
    assign oVS          = r_vs;
    assign oBLANK_n     = r_blank_n;
    assign oColor_SW    = r_color;
    assign oFrame_Start = (r_h_cnt == '0) && (r_v_cnt == '0);

    // Pixel and line counters
    always_ff @(posedge iVGA_CLK) begin
        if (iRST) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (w_h_last) begin
            r_h_cnt <= '0;
            r_v_cnt <= w_v_last ? '0 : r_v_cnt + CNT_W'(1);
        end else begin
            r_h_cnt <= r_h_cnt + CNT_W'(1);
        end
    end

    // Syncs and blank registered one cycle late to line up with the registered colour
    always_ff @(posedge iVGA_CLK) begin
        if (iRST) begin
            r_hs      <= 1'b1;
            r_vs      <= 1'b1;
            r_blank_n <= 1'b0;
        end else begin
            r_hs      <= !in_window(r_h_cnt, H_ACTIVE + H_FP, H_SYNC);
            r_vs      <= !in_window(r_v_cnt, V_ACTIVE + V_FP, V_SYNC);
            r_blank_n <= (int'(r_h_cnt) < H_ACTIVE) && (int'(r_v_cnt) < V_ACTIVE);
        end
    end

    // Pattern select: requests collect in a sticky flag and apply once per frame boundary
    always_ff @(posedge iVGA_CLK) begin
        if (iRST) begin
            r_color     <= 1'b0;
            r_pending   <= 1'b0;
            r_frame_cnt <= '0;
        end else if (w_frame_end) begin
            if (w_toggle) begin
                r_color <= ~r_color;
            end
            // a press landing on the boundary itself is carried to the next frame
            r_pending   <= w_press;
            r_frame_cnt <= (w_toggle || !iAuto_EN) ? '0 : r_frame_cnt + 8'd1;
        end else if (w_press) begin
            r_pending <= 1'b1;
        end
    end

endmodule
